tone_arbiter: RTL

Sequencer/arbiter sharing the single square-wave output between four pushbutton requesters. Each key press queues a tone request. A round-robin arbiter grants the wave generator to one channel at a time, plays a fixed-length tone whose pitch depends on the channel and the switches, then inserts a silent gap. The block sits in the top level beside the Nios system, driving the speaker pin and a seven-segment digit with the active channel.

---
 rtl/tone_arbiter_if.sv | 21 ++
 rtl/tone_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tone_arbiter_if.sv
// Pin-level bundle between the tone arbiter and the board: keys, switches,
// speaker wave and the status outputs.
interface tone_arbiter_if;
  logic [3:0] pushbutton;
  logic [7:0] switches;
  logic       out_wave;
  logic [3:0] grant;
  logic [3:0] pending;
  logic       busy;
  logic [6:0] hex_code;

  modport master (
    output pushbutton, switches,
    input  out_wave, grant, pending, busy, hex_code
  );

  modport slave (
    input  pushbutton, switches,
    output out_wave, grant, pending, busy, hex_code
  );
endinterface

// File: rtl/tone_arbiter.sv
// Round-robin sequencer sharing one square-wave speaker output between four
// pushbutton requesters, with a silent gap after every tone.
module tone_arbiter #(
  parameter int unsigned HALF_BASE  = 25000,
  parameter int unsigned SW_STEP    = 1000,
  parameter int unsigned DUR_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic           clk_clk,
  input  logic           reset_reset,
  tone_arbiter_if.slave  bus
);

  localparam int CW = 25;
  localparam longint unsigned CNT_LIM  = 64'd1 << CW;
  localparam longint unsigned HALF_MAX =
    longint'(HALF_BASE) * 4 + longint'(SW_STEP) * 255;

  // Refuse to elaborate with parameters that overflow the 25-bit counters.
  if (HALF_BASE == 0) begin : g_bad_half_base
    $error("tone_arbiter: HALF_BASE must be at least 1");
  end
  if (HALF_MAX >= CNT_LIM) begin : g_bad_half_max
    $error("tone_arbiter: HALF_BASE*4 + 255*SW_STEP does not fit in 25 bits");
  end
  if (DUR_CYCLES == 0 || longint'(DUR_CYCLES) >= CNT_LIM) begin : g_bad_dur
    $error("tone_arbiter: DUR_CYCLES must be in 1 .. 2**25-1");
  end
  if (GAP_CYCLES == 0 || longint'(GAP_CYCLES) >= CNT_LIM) begin : g_bad_gap
    $error("tone_arbiter: GAP_CYCLES must be in 1 .. 2**25-1");
  end

  localparam logic [CW-1:0] DUR_LAST = CW'(DUR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [6:0]    HEX_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  function automatic logic [CW-1:0] half_for(input logic [1:0] ch,
                                             input logic [7:0] sw);
    logic [CW-1:0] mult;
    mult = CW'({1'b0, ch}) + CW'(1);
    return CW'(HALF_BASE) * mult + CW'(sw) * CW'(SW_STEP);
  endfunction

  function automatic logic [6:0] hex_for(input logic [1:0] ch);
    logic [6:0] seg;
    case (ch)
      2'd0:    seg = 7'b1000000;
      2'd1:    seg = 7'b1111001;
      2'd2:    seg = 7'b0100100;
      default: seg = 7'b0110000;
    endcase
    return seg;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    sync1_q, sync2_q, prev_q;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    grant_q, grant_d;
  logic          out_wave_q, out_wave_d;
  logic          busy_q, busy_d;
  logic [6:0]    hex_q, hex_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] dur_q, dur_d;

  logic [3:0]    press;
  logic [3:0]    grant_clr;
  logic          win_found;
  logic [1:0]    win_idx;
  logic [1:0]    probe;

  assign press = prev_q & ~sync2_q;

  // Search last+1 .. last+4 (mod 4); the first pending channel wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    probe     = last_q;
    for (int k = 1; k <= 4; k++) begin
      probe = last_q + 2'(k);
      if (!win_found && pending_q[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    out_wave_d = out_wave_q;
    busy_d     = busy_q;
    hex_d      = hex_q;
    half_d     = half_q;
    wcnt_d     = wcnt_q;
    dur_d      = dur_q;
    grant_clr  = '0;

    case (state_q)
      S_IDLE: begin
        grant_d    = '0;
        out_wave_d = 1'b0;
        busy_d     = 1'b0;
        hex_d      = HEX_OFF;
        if (win_found) begin
          state_d    = S_PLAY;
          last_d     = win_idx;
          grant_d    = 4'b0001 << win_idx;
          grant_clr  = 4'b0001 << win_idx;
          out_wave_d = 1'b1;
          busy_d     = 1'b1;
          hex_d      = hex_for(win_idx);
          half_d     = half_for(win_idx, bus.switches);
          wcnt_d     = '0;
          dur_d      = '0;
        end
      end

      S_PLAY: begin
        if (dur_q == DUR_LAST) begin
          state_d    = S_GAP;
          grant_d    = '0;
          out_wave_d = 1'b0;
          hex_d      = HEX_OFF;
          dur_d      = '0;
        end else begin
          dur_d = dur_q + CW'(1);
          if (wcnt_q == half_q - CW'(1)) begin
            out_wave_d = ~out_wave_q;
            wcnt_d     = '0;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end

      S_GAP: begin
        if (dur_q == GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          dur_d = dur_q + CW'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        grant_d    = '0;
        out_wave_d = 1'b0;
        busy_d     = 1'b0;
        hex_d      = HEX_OFF;
      end
    endcase

    // A new press beats the grant clear on the same bit.
    pending_d = (pending_q & ~grant_clr) | press;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= S_IDLE;
      last_q     <= 2'd3;
      sync1_q    <= '1;
      sync2_q    <= '1;
      prev_q     <= '1;
      pending_q  <= '0;
      grant_q    <= '0;
      out_wave_q <= 1'b0;
      busy_q     <= 1'b0;
      hex_q      <= HEX_OFF;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sync1_q    <= bus.pushbutton;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      out_wave_q <= out_wave_d;
      busy_q     <= busy_d;
      hex_q      <= hex_d;
    end
  end

  // Counters and pitch are always reloaded on PLAY entry, so they need no reset.
  always_ff @(posedge clk_clk) begin
    half_q <= half_d;
    wcnt_q <= wcnt_d;
    dur_q  <= dur_d;
  end

  assign bus.out_wave = out_wave_q;
  assign bus.grant    = grant_q;
  assign bus.pending  = pending_q;
  assign bus.busy     = busy_q;
  assign bus.hex_code = hex_q;

endmodule
